// File: rtl/mem_channel_arbiter.sv
// Responder end of the core memory channel: arbitrates NUM_CONSUMERS request lanes onto
// NUM_CHANNELS memory channels with per-channel round-robin and lane claim bits.
module mem_channel_arbiter #(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned NUM_CHANNELS  = 1,
  parameter int unsigned WRITE_ENABLE  = 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid_i,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address_i,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready_o,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data_o,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid_i,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address_i,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data_i,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready_o,
  output logic [NUM_CHANNELS-1:0]              mem_read_valid_o,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]    mem_read_address_o,
  input  logic [NUM_CHANNELS-1:0]              mem_read_ready_i,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]    mem_read_data_i,
  output logic [NUM_CHANNELS-1:0]              mem_write_valid_o,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]    mem_write_address_o,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]    mem_write_data_o,
  input  logic [NUM_CHANNELS-1:0]              mem_write_ready_i
);

  localparam int unsigned LaneW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [LaneW:0]   NumLanes = (LaneW + 1)'(NUM_CONSUMERS);
  localparam logic [LaneW-1:0] LastLane = LaneW'(NUM_CONSUMERS - 1);
  localparam bit WriteEn = (WRITE_ENABLE != 0);

  typedef enum logic [2:0] {
    StIdle,
    StReadWait,
    StWriteWait,
    StReadRelay,
    StWriteRelay
  } state_e;

  state_e                   state_q [NUM_CHANNELS];
  state_e                   state_d [NUM_CHANNELS];
  logic [LaneW-1:0]         lane_q  [NUM_CHANNELS];
  logic [LaneW-1:0]         lane_d  [NUM_CHANNELS];
  logic [LaneW-1:0]         rr_q    [NUM_CHANNELS];
  logic [LaneW-1:0]         rr_d    [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     addr_d  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     wdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     wdata_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  mrv_q, mrv_d, mwv_q, mwv_d;
  logic [NUM_CONSUMERS-1:0] claim_q, claim_d, crr_q, crr_d, cwr_q, cwr_d;
  logic [DATA_BITS-1:0]     rdata_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     rdata_d [NUM_CONSUMERS];

  // Lanes granted earlier in this cycle; released claims only become visible next cycle.
  logic [NUM_CONSUMERS-1:0] taken;
  logic                     found;
  logic [LaneW-1:0]         pick;
  logic [LaneW:0]           scan_idx;

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    rr_d     = rr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mrv_d    = mrv_q;
    mwv_d    = mwv_q;
    claim_d  = claim_q;
    crr_d    = crr_q;
    cwr_d    = cwr_q;
    rdata_d  = rdata_q;
    taken    = '0;
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      unique case (state_q[c])
        StIdle: begin
          found = 1'b0;
          pick  = '0;
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
            scan_idx = {1'b0, rr_q[c]} + (LaneW + 1)'(k);
            if (scan_idx >= NumLanes) scan_idx = scan_idx - NumLanes;
            if (!found && !claim_q[scan_idx] && !taken[scan_idx] &&
                (consumer_read_valid_i[scan_idx] ||
                 (WriteEn && consumer_write_valid_i[scan_idx]))) begin
              found = 1'b1;
              pick  = scan_idx[LaneW-1:0];
            end
          end
          if (found) begin
            taken[pick]   = 1'b1;
            claim_d[pick] = 1'b1;
            lane_d[c]     = pick;
            if (consumer_read_valid_i[pick]) begin
              addr_d[c]  = consumer_read_address_i[pick*ADDR_BITS +: ADDR_BITS];
              mrv_d[c]   = 1'b1;
              state_d[c] = StReadWait;
            end else begin
              addr_d[c]  = consumer_write_address_i[pick*ADDR_BITS +: ADDR_BITS];
              wdata_d[c] = consumer_write_data_i[pick*DATA_BITS +: DATA_BITS];
              mwv_d[c]   = 1'b1;
              state_d[c] = StWriteWait;
            end
          end
        end
        StReadWait: begin
          if (mem_read_ready_i[c]) begin
            mrv_d[c]              = 1'b0;
            rdata_d[lane_q[c]]    = mem_read_data_i[c*DATA_BITS +: DATA_BITS];
            crr_d[lane_q[c]]      = 1'b1;
            state_d[c]            = StReadRelay;
          end
        end
        StWriteWait: begin
          if (mem_write_ready_i[c]) begin
            mwv_d[c]              = 1'b0;
            cwr_d[lane_q[c]]      = 1'b1;
            state_d[c]            = StWriteRelay;
          end
        end
        StReadRelay: begin
          if (!consumer_read_valid_i[lane_q[c]]) begin
            crr_d[lane_q[c]]   = 1'b0;
            claim_d[lane_q[c]] = 1'b0;
            rr_d[c]    = (lane_q[c] == LastLane) ? '0 : lane_q[c] + 1'b1;
            state_d[c] = StIdle;
          end
        end
        StWriteRelay: begin
          if (!consumer_write_valid_i[lane_q[c]]) begin
            cwr_d[lane_q[c]]   = 1'b0;
            claim_d[lane_q[c]] = 1'b0;
            rr_d[c]    = (lane_q[c] == LastLane) ? '0 : lane_q[c] + 1'b1;
            state_d[c] = StIdle;
          end
        end
        default: state_d[c] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= StIdle;
        lane_q[c]  <= '0;
        rr_q[c]    <= '0;
        addr_q[c]  <= '0;
        wdata_q[c] <= '0;
      end
      for (int l = 0; l < NUM_CONSUMERS; l++) rdata_q[l] <= '0;
      mrv_q   <= '0;
      mwv_q   <= '0;
      claim_q <= '0;
      crr_q   <= '0;
      cwr_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mrv_q   <= mrv_d;
      mwv_q   <= mwv_d;
      claim_q <= claim_d;
      crr_q   <= crr_d;
      cwr_q   <= cwr_d;
    end
  end

  always_comb begin
    consumer_read_data_o = '0;
    mem_read_address_o   = '0;
    mem_write_address_o  = '0;
    mem_write_data_o     = '0;
    for (int l = 0; l < NUM_CONSUMERS; l++) begin
      consumer_read_data_o[l*DATA_BITS +: DATA_BITS] = rdata_q[l];
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      mem_read_address_o[c*ADDR_BITS +: ADDR_BITS]  = addr_q[c];
      mem_write_address_o[c*ADDR_BITS +: ADDR_BITS] = WriteEn ? addr_q[c] : '0;
      mem_write_data_o[c*DATA_BITS +: DATA_BITS]    = WriteEn ? wdata_q[c] : '0;
    end
  end

  assign consumer_read_ready_o  = crr_q;
  assign consumer_write_ready_o = WriteEn ? cwr_q : '0;
  assign mem_read_valid_o       = mrv_q;
  assign mem_write_valid_o      = WriteEn ? mwv_q : '0;

endmodule
